ldpc_seq_encoder: RTL and testbench

Parametrised, handshaked successor to the combinational LDPC encoder top. It holds a run-time-loadable K x N generator matrix in an internal register file. It encodes one K-bit information word per transaction by row-serial GF(2) accumulation, one generator row per cycle. It sits between the info-word source and the codeword sink, using valid/ready on both sides.

---
 rtl/ldpc_seq_encoder.sv | 137 +++++++++++++
 tb/tb_ldpc_seq_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_seq_encoder.sv
// Row-serial GF(2) LDPC encoder with a run-time loadable K x N generator matrix and valid/ready on both sides.
// Optional build macro LDPC_ENC_ZERO_SKIP_EN: visit only the generator rows selected by set info bits.
module ldpc_seq_encoder #(
    parameter int N  = 11,
    parameter int K  = 6,
    parameter int AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_g_wr_en,
    input  logic [AW-1:0] i_g_wr_addr,
    input  logic [N-1:0]  i_g_wr_row,
    output logic          o_g_err,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [K-1:0]  i_info,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [N-1:0]  o_codeword,
    output logic          o_busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t        state;
    logic [N-1:0]  gen [K];
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_next;
    logic [K-1:0]  mask;
    logic [K-1:0]  mask_next;
    logic [K-1:0]  info_rev;
    logic [AW-1:0] sel_row;
    logic          last_row;
    logic          g_wr_ok;

    // mask bit k corresponds to generator row k, so i_info is bit-reversed on capture
    always_comb begin
        info_rev = '0;
        for (int k = 0; k < K; k++) begin
            info_rev[k] = i_info[K-1-k];
        end
    end

    assign g_wr_ok = (state == IDLE) && ({1'b0, i_g_wr_addr} < (AW+1)'(K));

`ifdef LDPC_ENC_ZERO_SKIP_EN
    // Lowest set row first; clearing the lowest set bit retires it
    always_comb begin
        sel_row = '0;
        for (int k = K-1; k >= 0; k--) begin
            if (mask[k]) begin
                sel_row = AW'(k);
            end
        end
        acc_next  = (mask != '0) ? (acc ^ gen[sel_row]) : acc;
        mask_next = mask & (mask - K'(1));
        last_row  = (mask_next == '0);
    end
`else
    logic [AW-1:0] row;

    // Fixed schedule: mask is shifted so bit 0 always belongs to the current row
    always_comb begin
        sel_row   = row;
        acc_next  = mask[0] ? (acc ^ gen[sel_row]) : acc;
        mask_next = mask >> 1;
        last_row  = (row == AW'(K-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (state == IDLE) begin
            row <= '0;
        end else if (state == ACC) begin
            row <= row + AW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_g_err    <= 1'b0;
            o_codeword <= '0;
            acc        <= '0;
            mask       <= '0;
            for (int k = 0; k < K; k++) begin
                gen[k] <= '0;
            end
        end else begin
            o_g_err <= i_g_wr_en && !g_wr_ok;
            if (i_g_wr_en && g_wr_ok) begin
                gen[i_g_wr_addr] <= i_g_wr_row;
            end
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        mask    <= info_rev;
                        acc     <= '0;
                        state   <= ACC;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                ACC: begin
                    acc  <= acc_next;
                    mask <= mask_next;
                    if (last_row) begin
                        state      <= DONE;
                        o_busy     <= 1'b0;
                        o_valid    <= 1'b1;
                        o_codeword <= acc_next;
                    end
                end
                DONE: begin
                    // o_ready rises only after the handshake edge, so no same-cycle re-accept
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_seq_encoder.sv
// Directed bench for ldpc_seq_encoder with the N=11, K=6 systematic generator.
module tb_ldpc_seq_encoder;

    localparam int N  = 11;
    localparam int K  = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_g_wr_en;
    logic [AW-1:0] i_g_wr_addr;
    logic [N-1:0]  i_g_wr_row;
    logic          o_g_err;
    logic          i_valid;
    logic          o_ready;
    logic [K-1:0]  i_info;
    logic          o_valid;
    logic          i_ready;
    logic [N-1:0]  o_codeword;
    logic          o_busy;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] g_rows [K];

    ldpc_seq_encoder #(.N(N), .K(K), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_g_wr_en(i_g_wr_en), .i_g_wr_addr(i_g_wr_addr), .i_g_wr_row(i_g_wr_row),
        .o_g_err(o_g_err),
        .i_valid(i_valid), .o_ready(o_ready), .i_info(i_info),
        .o_valid(o_valid), .i_ready(i_ready), .o_codeword(o_codeword),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [K-1:0] info);
`ifdef LDPC_ENC_ZERO_SKIP_EN
        return ($countones(info) == 0) ? 1 : $countones(info);
`else
        return K;
`endif
    endfunction

    task automatic load_g();
        for (int k = 0; k < K; k++) begin
            i_g_wr_en   = 1'b1;
            i_g_wr_addr = 3'(k);
            i_g_wr_row  = g_rows[k];
            @(posedge clk); #1;
        end
        i_g_wr_en = 1'b0;
    endtask

    // Starts at #1 after an edge in IDLE; returns #1 after the edge where o_valid rose
    task automatic do_encode(input logic [K-1:0] info, output logic [N-1:0] cw,
                             output int lat, output int busy_bad);
        i_valid = 1'b1;
        i_info  = info;
        @(posedge clk); #1;
        i_valid  = 1'b0;
        lat      = 0;
        busy_bad = 0;
        while (o_valid !== 1'b1 && lat < 40) begin
            if (o_ready !== 1'b0 || o_busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        cw = o_codeword;
    endtask

    task automatic test_reset();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_g_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_gerr: got %b expected 0", o_g_err); end
        checks++; if (o_codeword !== 11'b0) begin errors++; $display("[TB] FAIL reset_cw: got %b expected 0", o_codeword); end
    endtask

    task automatic test_encode(input string name, input logic [K-1:0] info, input logic [N-1:0] exp_cw);
        logic [N-1:0] cw;
        int lat, bad;
        i_ready = 1'b1;
        do_encode(info, cw, lat, bad);
        checks++; if (cw !== exp_cw) begin errors++; $display("[TB] FAIL %s_cw: got %b expected %b", name, cw, exp_cw); end
        checks++; if (lat != exp_lat(info)) begin errors++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat(info)); end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL %s_ready_busy_in_acc: got %0d bad cycles expected 0", name, bad); end
        @(posedge clk); #1;
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_handshake: got ready=%b valid=%b expected ready=1 valid=0", name, o_ready, o_valid); end
        checks++; if (o_codeword !== exp_cw) begin errors++; $display("[TB] FAIL %s_cw_hold: got %b expected %b", name, o_codeword, exp_cw); end
    endtask

    task automatic test_back_pressure();
        logic [N-1:0] cw;
        int lat, bad;
        i_ready = 1'b0;
        do_encode(6'b100000, cw, lat, bad);
        checks++; if (cw !== 11'b10000011000) begin errors++; $display("[TB] FAIL bp_cw: got %b expected 10000011000", cw); end
        i_valid = 1'b1;
        i_info  = 6'b000001;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_codeword !== 11'b10000011000) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b ready=%b cw=%b expected valid=1 ready=0 cw=10000011000", c, o_valid, o_ready, o_codeword);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", o_ready, o_valid); end
        @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0 || o_codeword !== 11'b10000011000) begin errors++; $display("[TB] FAIL bp_no_accept: got busy=%b cw=%b expected busy=0 cw=10000011000", o_busy, o_codeword); end
    endtask

    task automatic test_gen_err();
        int n;
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_info  = 6'b000001;
        @(posedge clk); #1;
        i_valid     = 1'b0;
        i_g_wr_en   = 1'b1;
        i_g_wr_addr = 3'd2;
        i_g_wr_row  = 11'h7FF;
        @(posedge clk); #1;
        i_g_wr_en = 1'b0;
        checks++; if (o_g_err !== 1'b1) begin errors++; $display("[TB] FAIL err_acc_pulse: got %b expected 1", o_g_err); end
        @(posedge clk); #1;
        checks++; if (o_g_err !== 1'b0) begin errors++; $display("[TB] FAIL err_acc_clear: got %b expected 0", o_g_err); end
        n = 0;
        while (o_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (o_codeword !== 11'b00000111111) begin errors++; $display("[TB] FAIL err_acc_cw: got %b expected 00000111111", o_codeword); end
        @(posedge clk); #1;
        i_g_wr_en   = 1'b1;
        i_g_wr_addr = 3'd6;
        i_g_wr_row  = 11'h7FF;
        @(posedge clk); #1;
        i_g_wr_en = 1'b0;
        checks++; if (o_g_err !== 1'b1) begin errors++; $display("[TB] FAIL err_addr_pulse: got %b expected 1", o_g_err); end
        @(posedge clk); #1;
        checks++; if (o_g_err !== 1'b0) begin errors++; $display("[TB] FAIL err_addr_clear: got %b expected 0", o_g_err); end
        test_encode("row2", 6'b001000, 11'b00100000110);
    endtask

    task automatic test_same_edge_write();
        i_g_wr_en   = 1'b1;
        i_g_wr_addr = 3'd0;
        i_g_wr_row  = 11'b01010101010;
        test_encode("same_edge", 6'b100000, 11'b01010101010);
        i_g_wr_en = 1'b0;
        i_g_wr_en   = 1'b1;
        i_g_wr_addr = 3'd0;
        i_g_wr_row  = g_rows[0];
        @(posedge clk); #1;
        i_g_wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_info  = 6'b111111;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_codeword !== 11'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got valid=%b ready=%b busy=%b cw=%b expected 0 1 0 0", o_valid, o_ready, o_busy, o_codeword);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_encode("cleared_g", 6'b111111, 11'b0);
        load_g();
        test_encode("reload_ones", 6'b111111, 11'b11111111111);
    endtask

    initial begin
        g_rows[0] = 11'b10000011000;
        g_rows[1] = 11'b01000001100;
        g_rows[2] = 11'b00100000110;
        g_rows[3] = 11'b00010000011;
        g_rows[4] = 11'b00001010001;
        g_rows[5] = 11'b00000111111;
        rst_n       = 1'b0;
        i_g_wr_en   = 1'b0;
        i_g_wr_addr = '0;
        i_g_wr_row  = '0;
        i_valid     = 1'b0;
        i_info      = '0;
        i_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_g();
        checks++; if (o_g_err !== 1'b0) begin errors++; $display("[TB] FAIL load_gerr: got %b expected 0", o_g_err); end
        test_encode("all_ones", 6'b111111, 11'b11111111111);
        test_encode("row0", 6'b100000, 11'b10000011000);
        test_encode("row5", 6'b000001, 11'b00000111111);
        test_encode("zero", 6'b000000, 11'b0);
        test_back_pressure();
        test_gen_err();
        test_same_edge_write();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
